// File: rtl/load_store_unit.sv
// Sequential RV32I load/store unit: word-only memory accesses, lane extraction,
// sign/zero extension, read-modify-write for sub-word stores, and error screening.
module load_store_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [2:0]  mem_funct3,
  output logic        mem_wren,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          store_r;
  logic [2:0]    funct3_r;
  logic [1:0]    lane_r;
  logic [31:0]   wdata_r;
  logic [4:0]    rd_r;
  logic [31:0]   ea_s;
  logic          err_s;

  function automatic logic req_bad(input logic st, input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if (st) begin
      case (f3)
        3'b000:  bad = 1'b0;
        3'b001:  bad = lo[0];
        3'b010:  bad = (lo != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: bad = 1'b0;
        3'b001, 3'b101: bad = lo[0];
        3'b010:         bad = (lo != 2'b00);
        default:        bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [2:0] f3,
                                          input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {lo, 3'b000});
    h = 16'(word >> {lo[1], 4'b0000});
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Sub-word stores overwrite only their lane(s) of the word just read back.
  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wdata,
                                        input logic [2:0] f3, input logic [1:0] lo);
    logic [31:0] r;
    r = word;
    case (f3)
      3'b000:  r[{lo, 3'b000} +: 8] = wdata[7:0];
      3'b001:  r[{lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

  assign ea_s       = req_base + req_offset;
  assign err_s      = req_bad(req_store, req_funct3, ea_s[1:0]);
  assign req_ready  = (state_r == IDLE) && !reset;
  assign mem_funct3 = 3'b010;

  // Request sequencing and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      store_r     <= 1'b0;
      funct3_r    <= 3'b000;
      lane_r      <= 2'b00;
      wdata_r     <= 32'h0000_0000;
      rd_r        <= 5'd0;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'h0000_0000;
      resp_rd     <= 5'd0;
      resp_error  <= 1'b0;
      mem_address <= 32'h0000_0000;
      mem_wren    <= 1'b0;
      mem_data_in <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            store_r  <= req_store;
            funct3_r <= req_funct3;
            lane_r   <= ea_s[1:0];
            wdata_r  <= req_wdata;
            rd_r     <= req_rd;
            cnt_r    <= '0;
            if (err_s) begin
              state_r    <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
            end else if (req_store && (req_funct3 == 3'b010)) begin
              state_r     <= WRITE;
              mem_address <= {ea_s[31:2], 2'b00};
              mem_wren    <= 1'b1;
              mem_data_in <= req_wdata;
            end else begin
              state_r     <= READ;
              mem_address <= {ea_s[31:2], 2'b00};
            end
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          if (cnt_r == CW'(MEM_LATENCY - 1)) begin
            if (store_r) begin
              state_r     <= WRITE;
              mem_wren    <= 1'b1;
              mem_data_in <= merge(mem_data_out, wdata_r, funct3_r, lane_r);
            end else begin
              state_r     <= RESP;
              mem_address <= 32'h0000_0000;
              resp_valid  <= 1'b1;
              resp_rdata  <= extract(mem_data_out, funct3_r, lane_r);
              resp_rd     <= rd_r;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        WRITE: begin
          state_r     <= RESP;
          mem_wren    <= 1'b0;
          mem_address <= 32'h0000_0000;
          mem_data_in <= 32'h0000_0000;
          resp_valid  <= 1'b1;
          resp_rd     <= 5'd0;
          resp_rdata  <= 32'h0000_0000;
        end
        RESP: begin
          state_r    <= IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= 32'h0000_0000;
          resp_rd    <= 5'd0;
          resp_error <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: two instances (MEM_LATENCY 1 and 3) driven by
// random and directed requests, checked against an arithmetic model of the memory.
module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit rst_test;

  logic        reset       [2];
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic        req_store   [2];
  logic [2:0]  req_funct3  [2];
  logic [31:0] req_base    [2];
  logic [31:0] req_offset  [2];
  logic [31:0] req_wdata   [2];
  logic [4:0]  req_rd      [2];
  logic        resp_valid  [2];
  logic [31:0] resp_rdata  [2];
  logic [4:0]  resp_rd     [2];
  logic        resp_error  [2];
  logic [31:0] mem_address [2];
  logic [2:0]  mem_funct3  [2];
  logic        mem_wren    [2];
  logic [31:0] mem_data_in [2];
  logic [31:0] mem_data_out[2];

  load_store_unit #(.MEM_LATENCY(1)) dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_store(req_store[0]), .req_funct3(req_funct3[0]), .req_base(req_base[0]),
    .req_offset(req_offset[0]), .req_wdata(req_wdata[0]), .req_rd(req_rd[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_rd(resp_rd[0]),
    .resp_error(resp_error[0]), .mem_address(mem_address[0]), .mem_funct3(mem_funct3[0]),
    .mem_wren(mem_wren[0]), .mem_data_in(mem_data_in[0]), .mem_data_out(mem_data_out[0])
  );

  load_store_unit #(.MEM_LATENCY(3)) dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_store(req_store[1]), .req_funct3(req_funct3[1]), .req_base(req_base[1]),
    .req_offset(req_offset[1]), .req_wdata(req_wdata[1]), .req_rd(req_rd[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_rd(resp_rd[1]),
    .resp_error(resp_error[1]), .mem_address(mem_address[1]), .mem_funct3(mem_funct3[1]),
    .mem_wren(mem_wren[1]), .mem_data_in(mem_data_in[1]), .mem_data_out(mem_data_out[1])
  );

  // Memories cover 0x2000..0x203F; data becomes valid MEM_LATENCY edges after the address.
  logic [31:0] mem  [2][16];
  logic [31:0] refm [2][16];
  logic [31:0] p1, p2;

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++)
      if (mem_wren[g] === 1'b1) mem[g][mem_address[g][5:2]] <= mem_data_in[g];
    p1 <= mem[1][mem_address[1][5:2]];
    p2 <= p1;
  end
  assign mem_data_out[0] = mem[0][mem_address[0][5:2]];
  assign mem_data_out[1] = p2;

  typedef struct { int cyc; logic err; logic [4:0] rd; logic [31:0] rdata; bit chk_data; } exp_t;
  typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } wexp_t;
  exp_t  rq0[$], rq1[$];
  wexp_t wq0[$], wq1[$];

  task automatic chk(input int g, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %h want %h (cycle %0d)", name, g, act, exp, cyc);
    end
  endtask

  // Reference: effective-address arithmetic on a word array, no knowledge of internal states.
  task automatic issue(input int g, input bit st, input logic [2:0] f3, input logic [31:0] ea,
                       input logic [31:0] wd, input logic [4:0] rd);
    int ml, size, sh, idx, n, lat;
    longint word, mask, val;
    bit bad;
    logic [31:0] off;
    exp_t e;
    wexp_t w;
    n = 0;
    @(negedge clk);
    while (!req_ready[g] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(g, "req_ready_wait", req_ready[g], 1);
    if (!req_ready[g]) return;
    ml   = (g == 0) ? 1 : 3;
    size = 1 << (f3 % 4);
    sh   = 8 * int'(ea % 4);
    idx  = int'((ea - 32'h2000) / 4);
    if (st) bad = (f3 > 3'd2);
    else    bad = (f3 == 3'd3) || (f3 >= 3'd6);
    if (!bad && (ea % size) != 0) bad = 1'b1;
    word = {32'h0, refm[g][idx]};
    mask = (64'd1 << (8 * size)) - 64'd1;
    e.err = bad; e.rd = 5'd0; e.rdata = 32'h0; e.chk_data = 1'b1;
    if (bad) begin
      lat = 1;
    end else if (!st) begin
      val = (word >> sh) & mask;
      if (f3 < 3'd4 && size < 4 && val > mask / 2) val = val - mask - 64'd1;
      e.rdata = val[31:0];
      e.rd    = rd;
      lat     = ml + 1;
    end else begin
      w.addr = ea - (ea % 4);
      val    = (word & ~(mask << sh)) | (({32'h0, wd} & mask) << sh);
      w.data = val[31:0];
      w.cyc  = cyc + ((size == 4) ? 1 : ml + 1);
      refm[g][idx] = w.data;
      lat = (size == 4) ? 2 : ml + 2;
      e.chk_data = 1'b0;
      if (g == 0) wq0.push_back(w); else wq1.push_back(w);
    end
    e.cyc = cyc + lat;
    if (g == 0) rq0.push_back(e); else rq1.push_back(e);
    off = $urandom;
    req_valid[g]  = 1'b1;
    req_store[g]  = st;
    req_funct3[g] = f3;
    req_offset[g] = off;
    req_base[g]   = ea - off;
    req_wdata[g]  = wd;
    req_rd[g]     = rd;
    @(posedge clk);
    #1;
    req_valid[g]  = 1'b0;
    req_base[g]   = $urandom;
    req_wdata[g]  = $urandom;
    req_funct3[g] = 3'($urandom);
  endtask

  task automatic mon_resp(input int g);
    exp_t e;
    int sz;
    sz = (g == 0) ? rq0.size() : rq1.size();
    chk(g, "resp_expected", 32'(sz > 0), 1);
    if (sz > 0) begin
      if (g == 0) e = rq0.pop_front(); else e = rq1.pop_front();
      chk(g, "resp_cycle", cyc, e.cyc);
      chk(g, "resp_error", resp_error[g], e.err);
      chk(g, "resp_rd", resp_rd[g], e.rd);
      if (e.chk_data) chk(g, "resp_rdata", resp_rdata[g], e.rdata);
      chk(g, "mem_funct3", mem_funct3[g], 3'b010);
    end
  endtask

  task automatic mon_write(input int g);
    wexp_t w;
    int sz;
    sz = (g == 0) ? wq0.size() : wq1.size();
    chk(g, "write_expected", 32'(sz > 0), 1);
    if (sz > 0) begin
      if (g == 0) w = wq0.pop_front(); else w = wq1.pop_front();
      chk(g, "write_cycle", cyc, w.cyc);
      chk(g, "write_addr", mem_address[g], w.addr);
      chk(g, "write_data", mem_data_in[g], w.data);
    end
  endtask

  // Monitor: compares every DUT response and memory write against the scoreboard.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (reset[g] !== 1'b0 || (g == 0 && rst_test)) continue;
      if (resp_valid[g]) mon_resp(g);
      if (mem_wren[g]) mon_write(g);
    end
  end

  task automatic drain(input int g);
    int n, sz;
    n = 0;
    sz = (g == 0) ? rq0.size() + wq0.size() : rq1.size() + wq1.size();
    while (sz != 0 && n < 100) begin
      @(negedge clk);
      n++;
      sz = (g == 0) ? rq0.size() + wq0.size() : rq1.size() + wq1.size();
    end
    chk(g, "queue_drained", sz, 0);
  endtask

  task automatic random_ops(input int g, input int count);
    bit st;
    logic [2:0] f3;
    for (int i = 0; i < count; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (st && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
      issue(g, st, f3, 32'h2000 + 32'($urandom_range(0, 63)), $urandom, 5'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain(g);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n;
    logic [31:0] w;
    rst_test = 1'b0;
    for (int g = 0; g < 2; g++) begin
      reset[g] = 1'b1; req_valid[g] = 1'b0; req_store[g] = 1'b0; req_funct3[g] = 3'b000;
      req_base[g] = 32'h0; req_offset[g] = 32'h0; req_wdata[g] = 32'h0; req_rd[g] = 5'd0;
      for (int i = 0; i < 16; i++) begin
        w = $urandom;
        mem[g][i] = w;
        refm[g][i] = w;
      end
    end
    mem[0][0] = 32'h80FF1234; refm[0][0] = 32'h80FF1234;
    mem[0][1] = 32'hDEADBEEF; refm[0][1] = 32'hDEADBEEF;
    mem[1][0] = 32'hAABBCCDD; refm[1][0] = 32'hAABBCCDD;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk(g, "rst_req_ready", req_ready[g], 0);
      chk(g, "rst_resp_valid", resp_valid[g], 0);
      chk(g, "rst_mem_wren", mem_wren[g], 0);
      chk(g, "rst_mem_address", mem_address[g], 0);
      chk(g, "rst_mem_funct3", mem_funct3[g], 3'b010);
      chk(g, "rst_resp_rdata", resp_rdata[g], 0);
    end
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    #1;
    chk(0, "ready_after_reset", req_ready[0], 1);

    issue(0, 1'b0, 3'b010, 32'h2004, 32'h0, 5'd1);
    issue(0, 1'b0, 3'b000, 32'h2003, 32'h0, 5'd2);
    issue(0, 1'b0, 3'b100, 32'h2003, 32'h0, 5'd3);
    issue(0, 1'b0, 3'b101, 32'h2002, 32'h0, 5'd4);
    issue(0, 1'b1, 3'b010, 32'h2000, 32'h11223344, 5'd5);
    issue(0, 1'b1, 3'b001, 32'h2002, 32'h0000ABCD, 5'd7);
    issue(0, 1'b0, 3'b010, 32'h2002, 32'h0, 5'd8);
    issue(0, 1'b1, 3'b010, 32'h2001, 32'h0, 5'd0);
    issue(0, 1'b1, 3'b000, 32'h2001, 32'h12345677, 5'd0);
    issue(0, 1'b0, 3'b010, 32'h2000, 32'h0, 5'd9);
    issue(0, 1'b0, 3'b010, 32'h2004, 32'h0, 5'd0);
    random_ops(0, 150);

    issue(1, 1'b1, 3'b000, 32'h2001, 32'h00000055, 5'd0);
    issue(1, 1'b0, 3'b010, 32'h2000, 32'h0, 5'd6);
    issue(1, 1'b0, 3'b001, 32'h2003, 32'h0, 5'd6);
    random_ops(1, 150);

    // Abort an sh in its WRITE cycle with an asynchronous reset.
    rst_test = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b1; req_store[0] = 1'b1; req_funct3[0] = 3'b001;
    req_base[0] = 32'h2010; req_offset[0] = 32'h2; req_wdata[0] = $urandom; req_rd[0] = 5'd3;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (!mem_wren[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(0, "abort_wren_seen", mem_wren[0], 1);
    #1;
    reset[0] = 1'b1;
    #1;
    chk(0, "abort_wren_cleared", mem_wren[0], 0);
    chk(0, "abort_resp_valid", resp_valid[0], 0);
    chk(0, "abort_req_ready", req_ready[0], 0);
    chk(0, "abort_mem_address", mem_address[0], 0);
    @(negedge clk);
    reset[0] = 1'b0;
    #1;
    chk(0, "abort_ready_release", req_ready[0], 1);
    chk(0, "abort_mem_intact", mem[0][4], refm[0][4]);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid[0] || mem_wren[0]) seen = 1'b1;
    end
    chk(0, "abort_no_resp", 32'(seen), 0);
    rst_test = 1'b0;
    issue(0, 1'b0, 3'b010, 32'h2010, 32'h0, 5'd11);
    drain(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
